// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter
//   Shares one multi-cycle FPU adder among NUM_REQ requesters with round-robin
//   arbitration. The grantee's operands are latched onto the FPU inputs and held
//   for FPU_LATENCY cycles. The FPU result and status are then captured and
//   returned tagged with the requester id.
//
// Ports
//   clock_100Khz  system clock
//   reset         synchronous, active-high reset
//   req_valid     per-requester request
//   req_ready     one-hot accept pulse, driven only in IDLE
//   req_op_a/b    packed operands, requester i at [32i+31:32i]
//   fpu_op_a/b    operands to the FPU, changed only at an accept edge
//   fpu_data      FPU result
//   fpu_status    FPU status
//   rsp_valid     response valid, held until rsp_ready
//   rsp_ready     response consumer ready
//   rsp_id        index of the requester that owns the response
//   rsp_data      captured result
//   rsp_status    captured status
//   busy          high whenever the arbiter is not IDLE
//
// Build option
//   FPU_ARB_ZERO_BYPASS_EN: an operation with a zero operand skips the FPU. It
//   answers two cycles after accept and leaves fpu_op_a/b untouched.

module fpu_rr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int FPU_LATENCY = 10,
   parameter int STATUS_W    = 4
) (
   input  logic                         clock_100Khz,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [32*NUM_REQ-1:0]        req_op_a,
   input  logic [32*NUM_REQ-1:0]        req_op_b,
   output logic [31:0]                  fpu_op_a,
   output logic [31:0]                  fpu_op_b,
   input  logic [31:0]                  fpu_data,
   input  logic [STATUS_W-1:0]          fpu_status,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [31:0]                  rsp_data,
   output logic [STATUS_W-1:0]          rsp_status,
   output logic                         busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StWait, StCapture, StRespond} state_e;

   state_e          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant_id;
   logic [7:0]      cnt;

   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic [31:0]     sel_a;
   logic [31:0]     sel_b;

   // First asserted request at or above rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      logic [ID_W:0] pos;
      grant_found = 1'b0;
      grant_idx   = '0;
      pos         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (pos >= (ID_W+1)'(NUM_REQ)) begin
            pos = pos - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[pos[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = pos[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == ID_W'(k)) begin
            sel_a = req_op_a[32*k +: 32];
            sel_b = req_op_b[32*k +: 32];
         end
      end
   end

   // The accept is gated by reset so that no handshake is seen while the
   // arbiter is being cleared.
   always_comb begin
      req_ready = '0;
      if (state == StIdle && grant_found && !reset) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign busy = (state != StIdle);

`ifdef FPU_ARB_ZERO_BYPASS_EN
   logic        byp_q;
   logic [31:0] byp_data;
   logic        a_zero;
   logic        b_zero;
   logic [31:0] byp_value;

   // Zero means exponent and mantissa both clear. The sign is ignored.
   assign a_zero = (sel_a[30:0] == 31'd0);
   assign b_zero = (sel_b[30:0] == 31'd0);

   always_comb begin
      if (a_zero && b_zero) begin
         byp_value = {sel_a[31] & sel_b[31], 31'd0};
      end else if (a_zero) begin
         byp_value = sel_b;
      end else begin
         byp_value = sel_a;
      end
   end
`endif

   always_ff @(posedge clock_100Khz) begin
      if (reset) begin
         state      <= StIdle;
         rr_ptr     <= '0;
         grant_id   <= '0;
         cnt        <= '0;
         fpu_op_a   <= '0;
         fpu_op_b   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         rsp_status <= '0;
`ifdef FPU_ARB_ZERO_BYPASS_EN
         byp_q      <= 1'b0;
         byp_data   <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (grant_found) begin
                  grant_id <= grant_idx;
`ifdef FPU_ARB_ZERO_BYPASS_EN
                  if (a_zero || b_zero) begin
                     byp_q    <= 1'b1;
                     byp_data <= byp_value;
                     state    <= StCapture;
                  end else begin
                     byp_q    <= 1'b0;
                     fpu_op_a <= sel_a;
                     fpu_op_b <= sel_b;
                     cnt      <= 8'(FPU_LATENCY - 1);
                     state    <= StWait;
                  end
`else
                  fpu_op_a <= sel_a;
                  fpu_op_b <= sel_b;
                  cnt      <= 8'(FPU_LATENCY - 1);
                  state    <= StWait;
`endif
               end
            end
            StWait: begin
               if (cnt == 8'd0) begin
                  state <= StCapture;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            StCapture: begin
`ifdef FPU_ARB_ZERO_BYPASS_EN
               rsp_data   <= byp_q ? byp_data : fpu_data;
               rsp_status <= byp_q ? '0 : fpu_status;
`else
               rsp_data   <= fpu_data;
               rsp_status <= fpu_status;
`endif
               rsp_id    <= grant_id;
               rsp_valid <= 1'b1;
               rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
               state     <= StRespond;
            end
            StRespond: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb_fpu_rr_arbiter
//   Directed bench for fpu_rr_arbiter with a stub FPU, a transaction-level
//   reference model checked every cycle, and literal expectations per scenario.

module tb_fpu_rr_arbiter;

   localparam int NR = 4;
   localparam int NL = 10;
   localparam int SW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [32*NR-1:0] req_op_a;
   logic [32*NR-1:0] req_op_b;
   logic [31:0]     fpu_op_a;
   logic [31:0]     fpu_op_b;
   logic [31:0]     fpu_data;
   logic [SW-1:0]   fpu_status;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_data;
   logic [SW-1:0]   rsp_status;
   logic            busy;

   always #5 clk = ~clk;

   fpu_rr_arbiter #(
      .NUM_REQ     (NR),
      .FPU_LATENCY (NL),
      .STATUS_W    (SW)
   ) dut (
      .clock_100Khz (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op_a     (req_op_a),
      .req_op_b     (req_op_b),
      .fpu_op_a     (fpu_op_a),
      .fpu_op_b     (fpu_op_b),
      .fpu_data     (fpu_data),
      .fpu_status   (fpu_status),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .rsp_status   (rsp_status),
      .busy         (busy)
   );

   // Stub FPU: 2.0 + 1.0 gives 3.0, anything else a distinctive mix.
   function automatic logic [31:0] stub_data(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4000_0000 && b == 32'h3FE0_0000) return 32'h4010_0000;
      return a ^ b ^ 32'h1234_5678;
   endfunction

   function automatic logic [SW-1:0] stub_status(input logic [31:0] a, input logic [31:0] b);
      return a[3:0] ^ b[7:4] ^ 4'h5;
   endfunction

   assign fpu_data   = stub_data(fpu_op_a, fpu_op_b);
   assign fpu_status = stub_status(fpu_op_a, fpu_op_b);

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
   endtask

   // Reference model, transaction level: one op outstanding from accept until
   // the response handshake. The response appears m_lat cycles after accept.
   bit          chk_en = 1'b0;
   bit          m_out = 1'b0;
   int          m_age = 0;
   int          m_lat = 0;
   int          m_id = 0;
   int          m_ptr = 0;
   logic [31:0] m_rd = '0;
   logic [SW-1:0] m_rs = '0;
   logic [31:0] m_fa = '0;
   logic [31:0] m_fb = '0;

   int          c_g;
   int          c_idx;
   logic [31:0] c_a;
   logic [31:0] c_b;
   logic        c_rv;
   logic [NR-1:0] c_ready;

   always @(negedge clk) begin
      c_rv    = m_out && (m_age >= m_lat);
      c_ready = '0;
      c_g     = -1;
      if (!m_out && !reset) begin
         for (int k = 0; k < NR; k++) begin
            c_idx = (m_ptr + k) % NR;
            if (c_g < 0 && req_valid[c_idx]) c_g = c_idx;
         end
         if (c_g >= 0) c_ready[c_g] = 1'b1;
      end
      if (chk_en) begin
         chk("m_req_ready", 64'(req_ready), 64'(c_ready));
         chk("m_busy", 64'(busy), 64'(m_out));
         chk("m_rsp_valid", 64'(rsp_valid), 64'(c_rv));
         chk("m_fpu_op_a", 64'(fpu_op_a), 64'(m_fa));
         chk("m_fpu_op_b", 64'(fpu_op_b), 64'(m_fb));
         if (c_rv) begin
            chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
            chk("m_rsp_data", 64'(rsp_data), 64'(m_rd));
            chk("m_rsp_status", 64'(rsp_status), 64'(m_rs));
         end
      end
      if (reset) begin
         m_out  = 1'b0;
         m_ptr  = 0;
         m_fa   = '0;
         m_fb   = '0;
         chk_en = 1'b1;
      end else if (m_out) begin
         if (c_rv && rsp_ready) m_out = 1'b0;
         else m_age++;
      end else if (c_g >= 0) begin
         c_a   = req_op_a[32*c_g +: 32];
         c_b   = req_op_b[32*c_g +: 32];
         m_out = 1'b1;
         m_age = 1;
         m_id  = c_g;
         m_ptr = (c_g + 1) % NR;
         m_lat = NL + 2;
         m_rd  = stub_data(c_a, c_b);
         m_rs  = stub_status(c_a, c_b);
`ifdef FPU_ARB_ZERO_BYPASS_EN
         if (c_a[30:0] == 31'd0 || c_b[30:0] == 31'd0) begin
            m_lat = 2;
            m_rs  = '0;
            if (c_a[30:0] == 31'd0 && c_b[30:0] == 31'd0) m_rd = {c_a[31] & c_b[31], 31'd0};
            else if (c_a[30:0] == 31'd0) m_rd = c_b;
            else m_rd = c_a;
         end else begin
            m_fa = c_a;
            m_fb = c_b;
         end
`else
         m_fa = c_a;
         m_fb = c_b;
`endif
      end
   end

   task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
      req_op_a[32*id +: 32] = a;
      req_op_b[32*id +: 32] = b;
   endtask

   // Raise req_valid[id], wait for its accept, drop it after the accept edge.
   task automatic do_req(input int id, output time t);
      bit got;
      got = 1'b0;
      t = 0;
      req_valid[id] = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            got = 1'b1;
            t = $time;
         end
      end
      if (!got) chk("accept_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   // Returns at the negedge of the first cycle with rsp_valid high.
   task automatic wait_rsp(output time t);
      bit got;
      got = 1'b0;
      t = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            t = $time;
         end
      end
      if (!got) chk("rsp_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      time tg, tr;
      time tgs[$];
      int  gids[$];
      int  exp_ord[6];
      logic [31:0] h_data;
      logic [1:0]  h_id;
      logic [SW-1:0] h_st;

      exp_ord = '{0, 1, 2, 3, 0, 1};
      reset     = 1'b1;
      req_valid = '1;
      req_op_a  = '0;
      req_op_b  = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) set_op(i, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i));

      // Reset state, with requests asserted that must not be accepted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_fpu_op_a", 64'(fpu_op_a), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_status", 64'(rsp_status), 64'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      req_valid = '0;

      // Single request: 2.0 + 1.0.
      set_op(1, 32'h4000_0000, 32'h3FE0_0000);
      do_req(1, tg);
      wait_rsp(tr);
      chk("t1_latency", 64'((tr - tg) / 10), 64'(12));
      chk("t1_rsp_id", 64'(rsp_id), 64'(1));
      chk("t1_rsp_data", 64'(rsp_data), 64'h4010_0000);
      chk("t1_rsp_status", 64'(rsp_status), 64'(5));
      chk("t1_fpu_op_a", 64'(fpu_op_a), 64'h4000_0000);
      chk("t1_fpu_op_b", 64'(fpu_op_b), 64'h3FE0_0000);
      @(posedge clk);

      // All requesting continuously after a reset: strict rotation, 13 apart.
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < NR; i++) set_op(i, 32'h3F80_0000 + 32'(i << 12), 32'h4000_0000 + 32'(i));
      req_valid = '1;
      for (int c = 0; c < 200 && gids.size() < 6; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            chk("t2_onehot", 64'($countones(req_ready)), 64'(1));
            for (int i = 0; i < NR; i++) if (req_ready[i]) gids.push_back(i);
            tgs.push_back($time);
         end
      end
      @(posedge clk);
      #1 req_valid = '0;
      chk("t2_grant_count", 64'(gids.size()), 64'(6));
      for (int i = 0; i < gids.size() && i < 6; i++) chk("t2_grant_order", 64'(gids[i]), 64'(exp_ord[i]));
      for (int i = 1; i < tgs.size(); i++) chk("t2_grant_spacing", 64'((tgs[i] - tgs[i-1]) / 10), 64'(13));
      wait_rsp(tr);
      @(posedge clk);

      // Backpressure: response held 20 cycles, no grant while held.
      #1 rsp_ready = 1'b0;
      set_op(2, 32'h3F80_0000, 32'h4120_0000);
      do_req(2, tg);
      wait_rsp(tr);
      h_data = rsp_data;
      h_id   = rsp_id;
      h_st   = rsp_status;
      chk("t3_rsp_data", 64'(h_data), 64'h6C94_5678);
      chk("t3_rsp_id", 64'(h_id), 64'(2));
      @(posedge clk);
      #1 set_op(0, 32'h1111_0000, 32'h2222_0000);
      req_valid[0] = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("t3_hold_valid", 64'(rsp_valid), 64'(1));
         chk("t3_hold_data", 64'(rsp_data), 64'(h_data));
         chk("t3_hold_id", 64'(rsp_id), 64'(h_id));
         chk("t3_hold_status", 64'(rsp_status), 64'(h_st));
         chk("t3_hold_no_grant", 64'(req_ready), 64'(0));
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_hs_no_grant", 64'(req_ready), 64'(0));
      @(negedge clk);
      chk("t3_next_grant", 64'(req_ready), 64'b0001);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      wait_rsp(tr);
      @(posedge clk);

      // Reset mid-WAIT with the counter at 5, then 0 beats 2.
      #1 set_op(3, 32'h5555_0000, 32'h6666_0000);
      do_req(3, tg);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      set_op(2, 32'h7777_0000, 32'h8888_0000);
      req_valid = 4'b0101;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("t4_busy", 64'(busy), 64'(0));
      chk("t4_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t4_fpu_op_a", 64'(fpu_op_a), 64'(0));
      chk("t4_fpu_op_b", 64'(fpu_op_b), 64'(0));
      chk("t4_rsp_data", 64'(rsp_data), 64'(0));
      chk("t4_grant0", 64'(req_ready), 64'b0001);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
      chk("t4_rsp_id", 64'(rsp_id), 64'(0));
      chk("t4_rsp_data", 64'(rsp_data), 64'h2107_5678);
      @(posedge clk);

      // Zero operand: -2.0 + 0.
      #1 set_op(1, 32'hC000_0000, 32'h0000_0000);
      do_req(1, tg);
      wait_rsp(tr);
`ifdef FPU_ARB_ZERO_BYPASS_EN
      chk("t5_latency", 64'((tr - tg) / 10), 64'(2));
      chk("t5_rsp_data", 64'(rsp_data), 64'hC000_0000);
      chk("t5_rsp_status", 64'(rsp_status), 64'(0));
      chk("t5_fpu_op_a", 64'(fpu_op_a), 64'h1111_0000);
      chk("t5_fpu_op_b", 64'(fpu_op_b), 64'h2222_0000);
`else
      chk("t5_latency", 64'((tr - tg) / 10), 64'(12));
      chk("t5_rsp_data", 64'(rsp_data), 64'hD234_5678);
      chk("t5_rsp_status", 64'(rsp_status), 64'(5));
      chk("t5_fpu_op_a", 64'(fpu_op_a), 64'hC000_0000);
      chk("t5_fpu_op_b", 64'(fpu_op_b), 64'h0000_0000);
`endif
      chk("t5_rsp_id", 64'(rsp_id), 64'(1));
      @(posedge clk);

      // Sparse: req 3 alone, then 0 and 1 together after the wrap.
      #1 set_op(3, 32'h3F00_0000, 32'h3F00_0001);
      req_valid[3] = 1'b1;
      @(negedge clk);
      chk("t6_grant3", 64'(req_ready), 64'b1000);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
      chk("t6_rsp3_id", 64'(rsp_id), 64'(3));
      @(posedge clk);
      #1 set_op(0, 32'h4100_0000, 32'h4100_0002);
      set_op(1, 32'h4200_0000, 32'h4200_0003);
      req_valid = 4'b0011;
      @(negedge clk);
      chk("t6_grant0_wrap", 64'(req_ready), 64'b0001);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(tr);
      chk("t6_rsp0_id", 64'(rsp_id), 64'(0));
      @(posedge clk);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fpu_rr_arbiter.md
Name: fpu_rr_arbiter

Overview:
- Shares one multi-cycle FPU adder (32-bit format: 1 sign, 10 exponent, bias 511, 21 mantissa) among NUM_REQ requesters.
- Round-robin arbitration. Grantee's operands are held stable on the FPU inputs for FPU_LATENCY cycles, then the FPU result/status is captured and returned tagged with the requester id.
- Sits between the FPU instance and the client blocks in the same clock_100Khz domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FPU_LATENCY, 10, cycles from operands stable to data_out/status_out valid (1..255).
- STATUS_W, 4, width of FPU status_out.

Ports:
- clock_100Khz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot accept pulse; handshake on valid&ready.
- req_op_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i].
- req_op_b  in  32*NUM_REQ  operand B, same packing.
- fpu_op_a  out  32  to FPU Op_A_in.
- fpu_op_b  out  32  to FPU Op_B_in.
- fpu_data  in  32  from FPU data_out.
- fpu_status  in  STATUS_W  from FPU status_out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of requester owning the response.
- rsp_data  out  32  result.
- rsp_status  out  STATUS_W  captured status.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking: single clock, synchronous active-high reset, all state updated on posedge clock_100Khz.
- Reset: state=IDLE, rr pointer=0, latency counter=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_status=0, fpu_op_a=0, fpu_op_b=0, busy=0. Reset in any state aborts the operation; the in-flight response is discarded.
- IDLE:
  - If any req_valid is high, select the first asserted index searching from rr pointer upward with wrap.
  - Same cycle: assert req_ready for that index only (combinational).
  - Next edge: latch op_a/op_b into fpu_op_a/fpu_op_b, latch grant id, counter=FPU_LATENCY-1, go to WAIT.
- WAIT:
  - fpu_op_a/fpu_op_b held constant.
  - Counter decrements each cycle. At 0, go to CAPTURE.
  - Operands are therefore stable FPU_LATENCY cycles before the capture edge.
- CAPTURE (1 cycle):
  - rsp_data<=fpu_data, rsp_status<=fpu_status, rsp_id<=grant id, rsp_valid<=1.
  - rr pointer <= grant id+1, wrapping at NUM_REQ.
  - Go to RESPOND.
- RESPOND:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - No new grant is issued in the handshake cycle. Earliest next req_ready is the following cycle.
- req_ready is 0 in every state except IDLE.
- Requests: a requester must hold req_valid and its operands until accepted. Deasserting before accept is legal; that request is simply not granted.
- Latency: accept edge to rsp_valid = FPU_LATENCY+2 cycles.
- Throughput: one op per FPU_LATENCY+3 cycles with rsp_ready tied high.
- Fairness: with all NUM_REQ requesting continuously, grants go 0,1,2,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- fpu_op_a/fpu_op_b keep their last value in IDLE and RESPOND; they change only at the accept edge.

Optional Feature:
- FPU_ARB_ZERO_BYPASS_EN.
- When defined:
  - At accept, if either operand has exponent==0 and mantissa==0, skip WAIT and go directly to CAPTURE.
  - rsp_data = the other operand. If both are zero: {signA&signB, 31'b0}.
  - rsp_status = 0. FPU operands are not updated.
  - Latency = 2 cycles.
- When undefined: zero operands take the normal FPU path. The bypass logic is absent from the netlist.

Test Plan:
- Single request, FPU_LATENCY=10: req 1 sends A=0x40000000 (2.0), B=0x3FE00000 (1.0); stub FPU drives 0x40100000 (3.0) → req_ready[1] one pulse; rsp_valid 12 cycles later with rsp_id=1, rsp_data=0x40100000; fpu_op_* stable for all 10 WAIT cycles.
- All 4 request continuously, rsp_ready=1 → grant order 0,1,2,3,0,1; each req_ready a single pulse; consecutive grants 13 cycles apart.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_data/rsp_id/rsp_status unchanged and no req_ready pulse while held; one cycle after rsp_ready=1, next grant issues.
- Reset mid-WAIT (counter=5) → next cycle all outputs at reset values, busy=0, no rsp_valid; then pointer=0, so req 0 wins if both 0 and 2 request.
- Zero operand with FPU_ARB_ZERO_BYPASS_EN: A=0xC0000000 (-2.0), B=0 → rsp_data=0xC0000000, rsp_status=0, 2-cycle latency, fpu_op_* unchanged. Without the macro: same stimulus takes FPU_LATENCY+2 cycles and fpu_op_* are updated.
- Sparse requests: only req 3 then only req 0 → each granted in the first IDLE cycle it is valid; pointer wrap from 3 to 0 is correct.
